// File: rtl/ace_pkg.sv
// Shared ACE front-end constants and types used by the instruction buffer.
package ace_pkg;
    localparam int ACE_FETCH_W  = 8;
    localparam int ACE_DEC_W    = 4;
    localparam int ACE_INST_W   = 32;
    localparam int ACE_IB_DEPTH = 32;
    localparam int ACE_OFF_W    = $clog2(ACE_FETCH_W);

    typedef logic [ACE_INST_W-1:0] inst_t;
endpackage

// File: rtl/ace_instbuf_if.sv
// Fetch-to-decode bundle around the instruction buffer; slave is the buffer side.
interface ace_instbuf_if #(
    parameter int DEPTH = ace_pkg::ACE_IB_DEPTH,
    parameter int DEC_W = ace_pkg::ACE_DEC_W
);
    import ace_pkg::*;

    logic [ACE_FETCH_W-1:0]            inst_vld_d0_i;
    logic [ACE_FETCH_W*ACE_INST_W-1:0] inst_d0_i;
    logic                              flush_rt_i;
    logic                              dec_stall_i;
    logic                              instbuf_full_o;
    logic [DEC_W-1:0]                  dec_vld_o;
    logic [DEC_W*ACE_INST_W-1:0]       dec_inst_o;
    logic [$clog2(DEPTH):0]            instbuf_cnt_o;

    modport slave (
        input  inst_vld_d0_i, inst_d0_i, flush_rt_i, dec_stall_i,
        output instbuf_full_o, dec_vld_o, dec_inst_o, instbuf_cnt_o
    );

    modport master (
        output inst_vld_d0_i, inst_d0_i, flush_rt_i, dec_stall_i,
        input  instbuf_full_o, dec_vld_o, dec_inst_o, instbuf_cnt_o
    );
endinterface

// File: rtl/ace_instbuf_compact.sv
// Order-preserving compactor: each valid slot's destination offset is the
// number of valid slots below it; total is the group's popcount.
module ace_instbuf_compact
    import ace_pkg::*;
(
    input  logic [ACE_FETCH_W-1:0]                vld_i,
    output logic [ACE_FETCH_W-1:0][ACE_OFF_W-1:0] off_o,
    output logic [ACE_OFF_W:0]                    total_o
);
    logic [ACE_OFF_W:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < ACE_FETCH_W; i++) begin
            off_o[i] = acc[ACE_OFF_W-1:0];
            acc      = acc + {{ACE_OFF_W{1'b0}}, vld_i[i]};
        end
        total_o = acc;
    end
endmodule

// File: rtl/ace_instbuf.sv
// Instruction buffer: circular queue between fetch d0 and decode, with
// margin-based back-pressure and a two-cycle squash window after retire flush.
module ace_instbuf
    import ace_pkg::*;
#(
    parameter int DEPTH       = ACE_IB_DEPTH,
    parameter int DEC_W       = ACE_DEC_W,
    parameter int FULL_MARGIN = 16
) (
    input logic          clock,
    input logic          reset,
    ace_instbuf_if.slave ib
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NXT_W = PTR_W + 2;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d, full_d1_q, full_d1_d;
    logic             flush_d1_q, flush_d1_d;
    inst_t            mem_q [DEPTH];
    inst_t            mem_d [DEPTH];

    logic [ACE_FETCH_W-1:0][ACE_OFF_W-1:0] slot_off;
    logic [ACE_OFF_W:0]                    grp_cnt;
    logic                                  squash, wr_en;
    logic [CNT_W-1:0]                      avail, rd_cnt;
    logic [NXT_W-1:0]                      wr_cnt, count_next;

    ace_instbuf_compact u_compact (
        .vld_i   (ib.inst_vld_d0_i),
        .off_o   (slot_off),
        .total_o (grp_cnt)
    );

    // A group presented while full_d1 is high is fetch's held copy of one already taken.
    always_comb begin
        squash     = ib.flush_rt_i | flush_d1_q;
        wr_en      = ~full_d1_q & ~squash;
        wr_cnt     = wr_en ? NXT_W'(grp_cnt) : '0;
        avail      = (count_q >= CNT_W'(DEC_W)) ? CNT_W'(DEC_W) : count_q;
        rd_cnt     = ib.dec_stall_i ? '0 : avail;
        count_next = NXT_W'(count_q) + wr_cnt - NXT_W'(rd_cnt);

        mem_d = mem_q;
        if (wr_en) begin
            for (int i = 0; i < ACE_FETCH_W; i++) begin
                if (ib.inst_vld_d0_i[i]) begin
                    mem_d[wr_ptr_q + PTR_W'(slot_off[i])] = ib.inst_d0_i[i*ACE_INST_W +: ACE_INST_W];
                end
            end
        end

        rd_ptr_d   = rd_ptr_q + PTR_W'(rd_cnt);
        wr_ptr_d   = wr_ptr_q + PTR_W'(wr_cnt);
        count_d    = count_next[CNT_W-1:0];
        full_d     = (count_next > NXT_W'(DEPTH - FULL_MARGIN));
        full_d1_d  = full_q;
        flush_d1_d = ib.flush_rt_i;

        if (ib.flush_rt_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            full_d   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            full_d1_q  <= 1'b0;
            flush_d1_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            full_d1_q  <= full_d1_d;
            flush_d1_q <= flush_d1_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_comb begin
        ib.dec_vld_o  = '0;
        ib.dec_inst_o = '0;
        for (int k = 0; k < DEC_W; k++) begin
            if (CNT_W'(k) < avail) begin
                ib.dec_vld_o[k]                              = 1'b1;
                ib.dec_inst_o[k*ACE_INST_W +: ACE_INST_W] = mem_q[rd_ptr_q + PTR_W'(k)];
            end
        end
    end

    assign ib.instbuf_full_o = full_q;
    assign ib.instbuf_cnt_o  = count_q;
endmodule
